// File: rtl/alu.sv
// Registered 8-bit ALU: 3-bit opcode, two 8-bit operands, 16-bit result (optional {C,Z} via ALU_FLAGS_EN).
// Latency 1 cycle, one op per edge, no backpressure; synchronous active-low reset clears all outputs.
module alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [18:0] inst,
`ifdef ALU_FLAGS_EN
   output logic [1:0]  flags,
`endif
   output logic [15:0] R
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_AND = 3'b011,
      OP_OR  = 3'b100,
      OP_XOR = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } op_e;

   op_e         op;
   logic [15:0] a16;
   logic [15:0] b16;
   logic [15:0] r_d;
   logic [15:0] r_q;

   always_comb begin
      op  = op_e'(inst[18:16]);
      a16 = {8'h00, inst[15:8]};
      b16 = {8'h00, inst[7:0]};
      r_d = 16'h0000;
      case (op)
         OP_ADD: r_d = a16 + b16;
         OP_SUB: r_d = a16 - b16;
         OP_MUL: r_d = a16 * b16;
         OP_AND: r_d = a16 & b16;
         OP_OR:  r_d = a16 | b16;
         OP_XOR: r_d = a16 ^ b16;
         OP_SHL: r_d = a16 << b16[3:0];
         OP_SHR: r_d = a16 >> b16[3:0];
         default: r_d = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= 16'h0000;
      end else begin
         r_q <= r_d;
      end
   end

   assign R = r_q;

`ifdef ALU_FLAGS_EN
   logic       c_d;
   logic [1:0] flags_d;
   logic [1:0] flags_q;

   // Carry meaning depends on the op: add carry-out, subtract borrow, multiply overflow past 8 bits.
   always_comb begin
      c_d = 1'b0;
      case (op)
         OP_ADD:  c_d = r_d[8];
         OP_SUB:  c_d = (a16 < b16);
         OP_MUL:  c_d = (r_d[15:8] != 8'h00);
         default: c_d = 1'b0;
      endcase
      flags_d = {c_d, (r_d == 16'h0000)};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_q <= 2'b00;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags = flags_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Randomized scoreboard bench for alu; flags are checked only when built with ALU_FLAGS_EN.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [18:0] inst;
   logic [15:0] R;
`ifdef ALU_FLAGS_EN
   logic [1:0]  flags;
`endif

   typedef struct {
      logic [15:0] r;
      logic [1:0]  f;
      string       name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 0;

   alu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .inst  (inst),
`ifdef ALU_FLAGS_EN
      .flags (flags),
`endif
      .R     (R)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input bit rst, input int op, input int a, input int b, input string name);
      exp_t e;
      int   res;
      bit   c;
      c   = 0;
      res = 0;
      if (rst) begin
         e.r = 16'h0000;
         e.f = 2'b00;
      end else begin
         case (op)
            0: begin res = a + b;                  c = (res >= 256); end
            1: begin res = (a - b + 65536) % 65536; c = (a < b);     end
            2: begin res = a * b;                  c = (res > 255);  end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: res = (a * (1 << (b % 16))) % 65536;
            default: res = a / (1 << (b % 16));
         endcase
         e.r = res[15:0];
         e.f = {c, (res == 0)};
      end
      e.name = name;
      return e;
   endfunction

   // Drive away from the sampling edge and record what that edge must produce.
   task automatic drive(input bit rst, input int op, input int a, input int b, input string name);
      @(negedge clk);
      rst_n = ~rst;
      inst  = {op[2:0], a[7:0], b[7:0]};
      q.push_back(model(rst, op, a, b, name));
   endtask

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare just after each edge, then again late in the cycle to prove the output held.
   initial begin
      exp_t cur;
      bit   have;
      have = 0;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            cur  = q.pop_front();
            have = 1;
            cmp({cur.name, "_R"}, int'(R), int'(cur.r));
`ifdef ALU_FLAGS_EN
            cmp({cur.name, "_flags"}, int'(flags), int'(cur.f));
`endif
         end else begin
            have = 0;
         end
         #7;
         if (have && !done) begin
            cmp({cur.name, "_hold"}, int'(R), int'(cur.r));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      inst  = '0;
      drive(1, 2, 8'h55, 8'h5D, "reset");
      drive(0, 2, 8'h55, 8'h5D, "mul_after_reset");
      drive(0, 2, 8'hFF, 8'hFF, "mul_max");
      drive(0, 0, 8'h55, 8'h5D, "add");
      drive(0, 0, 8'hFF, 8'h01, "add_carry");
      drive(0, 1, 8'h55, 8'h5D, "sub_borrow");
      drive(0, 1, 8'h5D, 8'h5D, "sub_zero");
      drive(0, 1, 8'h03, 8'h05, "sub_wrap");
      drive(0, 3, 8'h55, 8'h5D, "and");
      drive(0, 4, 8'h55, 8'h5D, "or");
      drive(0, 5, 8'h55, 8'h5D, "xor");
      drive(0, 3, 8'hF0, 8'h0F, "and_zero");
      drive(0, 6, 8'h55, 8'h04, "shl4");
      drive(0, 6, 8'h55, 8'h0D, "shl13");
      drive(0, 6, 8'hFF, 8'hFF, "shl15_hibits");
      drive(0, 7, 8'hF0, 8'h04, "shr4");
      drive(0, 7, 8'h80, 8'h0F, "shr_zero");
      drive(0, 7, 8'hAB, 8'hF0, "shr_hibits");
      drive(1, 0, 8'hFF, 8'hFF, "reset_midstream");
      drive(0, 0, 8'h01, 8'h02, "after_reset");
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 19) == 0), $urandom_range(0, 7),
               $urandom_range(0, 255), $urandom_range(0, 255), "rand");
      end
      @(posedge clk);
      @(posedge clk);
      #2;
      done = 1;
      cmp("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
